rf_wport_ctrl: RTL and testbench

- Owns the single write port of the 32x32 register file (regFile).
- Initialises the file after reset with a zero sweep, then arbitrates write requests from N writeback sources (e.g. ALU, load unit, multiply/divide) round-robin.
- Drives regFile's busW/wE/rW from registered outputs.
- regFile's read ports are not touched.

---
 rtl/rf_ctrl_pkg.sv | 21 ++
 rtl/rf_wport_ctrl_rr_arbiter.sv | 41 ++++
 rtl/rf_wport_ctrl.sv | 150 +++++++++++++++
 tb/tb_rf_wport_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port controller.
package rf_ctrl_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_LAST_REG = 31;
  localparam int unsigned SKIP_CNT_W  = 16;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_t;

  // One register-file write: destination and payload.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wport_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above i_ptr wins, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic           w_found;
  logic [PTR_W:0] w_sum;

  // Rotate requests so i_ptr sits at bit 0, pick the lowest set bit, then un-rotate the index.
  always_comb begin
    w_dbl     = {i_req, i_req} >> i_ptr;
    w_rot     = w_dbl[N-1:0];
    w_found   = 1'b0;
    w_sum     = '0;
    o_gnt_idx = '0;
    o_gnt     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (PTR_W+1)'(k);
      end
    end
    if (w_sum >= (PTR_W+1)'(N)) begin
      o_gnt_idx = PTR_W'(w_sum - (PTR_W+1)'(N));
    end else begin
      o_gnt_idx = PTR_W'(w_sum);
    end
    if (w_found) begin
      o_gnt = N'(1) << o_gnt_idx;
    end
  end

endmodule

// File: rtl/rf_wport_ctrl.sv
// Register-file write-port owner: zero sweep after reset, then round-robin writeback arbitration.
// Optional macro RF_ZERO_SKIP_EN: accepted writes to r0 are dropped and counted on skip_cnt.
module rf_wport_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned    N_REQ      = 2,
  parameter bit             INIT_SWEEP = 1'b1,
  parameter logic [31:0]    INIT_VALUE = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [RF_ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [RF_DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         wE,
  output logic [RF_ADDR_W-1:0]         rW,
  output logic [RF_DATA_W-1:0]         busW,
  output logic                         init_done
`ifdef RF_ZERO_SKIP_EN
  , output logic [SKIP_CNT_W-1:0]      skip_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_t                 r_state, w_state_nxt;
  logic [RF_ADDR_W-1:0]   r_sweep_cnt, w_sweep_nxt;
  logic [PTR_W-1:0]       r_rr_ptr, w_ptr_nxt;
  logic                   r_we, w_we_nxt;
  rf_wr_t                 r_wr, w_wr_nxt;
  logic                   r_init_done, w_init_done_nxt;
  logic [N_REQ-1:0]       w_gnt;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic [N_REQ-1:0]       w_ready;
  rf_wr_t                 w_sel;
`ifdef RF_ZERO_SKIP_EN
  logic [SKIP_CNT_W-1:0]  r_skip_cnt, w_skip_nxt;
`endif

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Accept only in ARB and never in a reset cycle; depends on valid/state, not data.
  always_comb begin
    w_ready = '0;
    if (r_state == ARB && !rst) begin
      w_ready = w_gnt;
    end
  end

  // Pick the granted requester's address/data (one-hot OR mux).
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel.addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
        w_sel.data = req_data[i*RF_DATA_W +: RF_DATA_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_nxt     = r_sweep_cnt;
    w_ptr_nxt       = r_rr_ptr;
    w_we_nxt        = 1'b0;
    w_wr_nxt        = r_wr;
    w_init_done_nxt = r_init_done;
`ifdef RF_ZERO_SKIP_EN
    w_skip_nxt      = r_skip_cnt;
`endif
    case (r_state)
      INIT: begin
        // The cycle presenting the last sweep write hands over to arbitration.
        if (r_we && r_wr.addr == RF_ADDR_W'(RF_LAST_REG)) begin
          w_state_nxt     = ARB;
          w_init_done_nxt = 1'b1;
        end else begin
          w_we_nxt      = 1'b1;
          w_wr_nxt.addr = r_sweep_cnt;
          w_wr_nxt.data = INIT_VALUE;
          w_sweep_nxt   = r_sweep_cnt + RF_ADDR_W'(1);
        end
      end
      ARB: begin
        w_init_done_nxt = 1'b1;
        if (|(req_valid & w_ready)) begin
          w_we_nxt = 1'b1;
          w_wr_nxt = w_sel;
`ifdef RF_ZERO_SKIP_EN
          if (w_sel.addr == '0) begin
            w_we_nxt   = 1'b0;
            w_skip_nxt = r_skip_cnt + SKIP_CNT_W'(1);
          end
`endif
          if (w_gnt_idx == PTR_W'(N_REQ-1)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = w_gnt_idx + PTR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT_SWEEP ? INIT : ARB;
      r_sweep_cnt <= RF_ADDR_W'(1);
      r_rr_ptr    <= '0;
      r_we        <= 1'b0;
      r_wr        <= '0;
      r_init_done <= 1'b0;
`ifdef RF_ZERO_SKIP_EN
      r_skip_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      r_we        <= w_we_nxt;
      r_wr        <= w_wr_nxt;
      r_init_done <= w_init_done_nxt;
`ifdef RF_ZERO_SKIP_EN
      r_skip_cnt  <= w_skip_nxt;
`endif
    end
  end

  assign req_ready = w_ready;
  assign wE        = r_we;
  assign rW        = r_wr.addr;
  assign busW      = r_wr.data;
  assign init_done = r_init_done;
`ifdef RF_ZERO_SKIP_EN
  assign skip_cnt  = r_skip_cnt;
`endif

endmodule

// File: tb/tb_rf_wport_ctrl.sv
// Directed bench for rf_wport_ctrl with a behavioural register file behind the write port.
module tb_rf_wport_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        wE;
  logic [4:0]  rW;
  logic [31:0] busW;
  logic        init_done;
`ifdef RF_ZERO_SKIP_EN
  logic [15:0] skip_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  rf_wport_ctrl #(
    .N_REQ      (2),
    .INIT_SWEEP (1'b1),
    .INIT_VALUE (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wE        (wE),
    .rW        (rW),
    .busW      (busW),
    .init_done (init_done)
`ifdef RF_ZERO_SKIP_EN
    , .skip_cnt (skip_cnt)
`endif
  );

  // Register file behind the port: r0 is hardwired, commit on the edge after wE is seen.
  always @(posedge clk) begin
    if (wE === 1'b1 && rW != 5'd0) rf[rW] <= busW;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[idx]        = v;
    req_addr[idx*5 +: 5]  = a;
    req_data[idx*32 +: 32] = d;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'hFFFF_FFFF;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    // Requester 0 waits through reset and the whole sweep.
    set_req(0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    tick;
    tick;
    chk("rst_we", 32'(wE), 32'd0);
    chk("rst_rw", 32'(rW), 32'd0);
    chk("rst_busw", busW, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
`ifdef RF_ZERO_SKIP_EN
    chk("rst_skip_cnt", 32'(skip_cnt), 32'd0);
`endif
    rst = 1'b0;

    for (int k = 1; k <= 31; k++) begin
      tick;
      chk("sweep_we", 32'(wE), 32'd1);
      chk("sweep_rw", 32'(rW), 32'(k));
      chk("sweep_busw", busW, 32'd0);
      chk("sweep_init_done", 32'(init_done), 32'd0);
      chk("sweep_ready", 32'(req_ready), 32'd0);
    end
    tick;
    chk("sweep_end_we", 32'(wE), 32'd0);
    chk("sweep_end_init_done", 32'(init_done), 32'd1);
    chk("arb_ready0", 32'(req_ready), 32'b01);
    for (int r = 1; r < 32; r++) chk("sweep_reg_zero", rf[r], 32'd0);

    // Single write: accept edge, then wE, then regFile commit.
    tick;
    chk("w8_we", 32'(wE), 32'd1);
    chk("w8_rw", 32'(rW), 32'd8);
    chk("w8_busw", busW, 32'hDEAD_BEEF);
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    tick;
    chk("idle_we", 32'(wE), 32'd0);
    chk("idle_rw_hold", 32'(rW), 32'd8);
    chk("idle_busw_hold", busW, 32'hDEAD_BEEF);
    chk("reg8", rf[8], 32'hDEAD_BEEF);

    // Both requesters busy: pointer is at 1 after the last grant, so order is 1,0,1,0.
    set_req(0, 1'b1, 5'd10, 32'h0000_00A0);
    set_req(1, 1'b1, 5'd11, 32'h0000_00B1);
    #1;
    chk("alt_ready_a", 32'(req_ready), 32'b10);
    tick;
    chk("alt_rw_a", 32'(rW), 32'd11);
    chk("alt_busw_a", busW, 32'h0000_00B1);
    set_req(1, 1'b1, 5'd12, 32'h0000_00B2);
    #1;
    chk("alt_ready_b", 32'(req_ready), 32'b01);
    tick;
    chk("alt_rw_b", 32'(rW), 32'd10);
    chk("alt_busw_b", busW, 32'h0000_00A0);
    set_req(0, 1'b1, 5'd13, 32'h0000_00A1);
    #1;
    chk("alt_ready_c", 32'(req_ready), 32'b10);
    tick;
    chk("alt_rw_c", 32'(rW), 32'd12);
    chk("alt_busw_c", busW, 32'h0000_00B2);
    set_req(1, 1'b1, 5'd9, 32'd5);
    #1;
    chk("alt_ready_d", 32'(req_ready), 32'b01);
    tick;
    chk("alt_rw_d", 32'(rW), 32'd13);
    chk("alt_busw_d", busW, 32'h0000_00A1);

    // Same destination on consecutive grants: requester 1 (5) then requester 0 (7).
    set_req(0, 1'b1, 5'd9, 32'd7);
    #1;
    chk("same_ready_a", 32'(req_ready), 32'b10);
    tick;
    chk("same_rw_a", 32'(rW), 32'd9);
    chk("same_busw_a", busW, 32'd5);
    set_req(1, 1'b0, 5'd0, 32'd0);
    #1;
    chk("same_ready_b", 32'(req_ready), 32'b01);
    tick;
    chk("same_rw_b", 32'(rW), 32'd9);
    chk("same_busw_b", busW, 32'd7);
    chk("same_we_b", 32'(wE), 32'd1);

    // Lone requester transfers back-to-back.
    set_req(0, 1'b1, 5'd14, 32'h0000_0014);
    #1;
    chk("lone_ready_a", 32'(req_ready), 32'b01);
    tick;
    chk("lone_rw_a", 32'(rW), 32'd14);
    chk("lone_busw_a", busW, 32'h0000_0014);
    chk("reg9_last_wins", rf[9], 32'd7);
    chk("reg10", rf[10], 32'h0000_00A0);
    chk("reg11", rf[11], 32'h0000_00B1);
    chk("reg12", rf[12], 32'h0000_00B2);
    chk("reg13", rf[13], 32'h0000_00A1);

    // Write to r0 immediately after.
    set_req(0, 1'b1, 5'd0, 32'd1);
    #1;
    chk("zero_ready", 32'(req_ready), 32'b01);
    tick;
`ifdef RF_ZERO_SKIP_EN
    chk("zero_we_skipped", 32'(wE), 32'd0);
    chk("zero_skip_cnt", 32'(skip_cnt), 32'd1);
`else
    chk("zero_we", 32'(wE), 32'd1);
    chk("zero_rw", 32'(rW), 32'd0);
    chk("zero_busw", busW, 32'd1);
`endif
    set_req(0, 1'b0, 5'd0, 32'd0);
    tick;
    chk("zero_after_we", 32'(wE), 32'd0);
    chk("reg14", rf[14], 32'h0000_0014);

    // Reset during arbitration: a pending request must not be accepted in the reset cycle.
    set_req(0, 1'b1, 5'd20, 32'd20);
    rst = 1'b1;
    #1;
    chk("rst_arb_ready", 32'(req_ready), 32'd0);
    tick;
    set_req(0, 1'b0, 5'd0, 32'd0);
    chk("rst_arb_we", 32'(wE), 32'd0);
    chk("rst_arb_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;

    // Partial sweep up to r12, then reset again.
    for (int k = 1; k <= 12; k++) begin
      tick;
      chk("part_rw", 32'(rW), 32'(k));
    end
    rst = 1'b1;
    tick;
    chk("midsweep_rst_we", 32'(wE), 32'd0);
    chk("midsweep_rst_rw", 32'(rW), 32'd0);
    chk("midsweep_rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick;
      chk("resweep_we", 32'(wE), 32'd1);
      chk("resweep_rw", 32'(rW), 32'(k));
      chk("resweep_init_done", 32'(init_done), 32'd0);
    end
    tick;
    chk("resweep_end_we", 32'(wE), 32'd0);
    chk("resweep_init_done_up", 32'(init_done), 32'd1);
    for (int r = 1; r < 32; r++) chk("resweep_reg_zero", rf[r], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
